// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared types and constants for the calculator engine and its divider.
//   arithmetic_t   : operation selected by the arif buttons
//   state_t        : entry/compute stages of the calculator FSM
//   LED_*          : one-hot stage indicator patterns driven onto led
//   pick_operation : lowest-index pressed operation button wins
// -----------------------------------------------------------------------------
package calc_pkg;

    typedef enum logic [1:0] {
        PLUS           = 2'd0,
        SUBTRACTION    = 2'd1,
        MULTIPLICATION = 2'd2,
        DIVISION       = 2'd3
    } arithmetic_t;

    typedef enum logic [1:0] {
        WAIT_A,
        WAIT_B,
        READY,
        DIVIDE
    } state_t;

    localparam logic [2:0] LED_WAIT_A = 3'b001;
    localparam logic [2:0] LED_WAIT_B = 3'b010;
    localparam logic [2:0] LED_READY  = 3'b100;

    // Only meaningful when at least one bit of ev is set.
    function automatic arithmetic_t pick_operation(input logic [3:0] ev);
        arithmetic_t op;
        if (ev[0])
            op = PLUS;
        else if (ev[1])
            op = SUBTRACTION;
        else if (ev[2])
            op = MULTIPLICATION;
        else
            op = DIVISION;
        return op;
    endfunction

endpackage

// File: rtl/calc_divider.sv
// -----------------------------------------------------------------------------
// calc_divider
// Restoring unsigned divider producing one quotient bit per clock.
//   clk, rst  : clock and asynchronous active-high reset (aborts a division)
//   start     : one-cycle request; operands are captured on this edge
//   dividend  : IN_WIDTH-bit unsigned numerator
//   divisor   : IN_WIDTH-bit unsigned denominator (caller guarantees non-zero)
//   done      : high in the cycle whose closing edge finishes the last step
//   quotient  : final quotient, valid while done is high
// Operands load on the start edge k; quotient bits are produced on edges
// k+1 .. k+IN_WIDTH, so the caller can take the answer on edge k+IN_WIDTH.
// -----------------------------------------------------------------------------
module calc_divider
    import calc_pkg::*;
#(
    parameter int IN_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [IN_WIDTH-1:0] dividend,
    input  logic [IN_WIDTH-1:0] divisor,
    output logic                done,
    output logic [IN_WIDTH-1:0] quotient
);

    localparam int CW = $clog2(IN_WIDTH + 1);

    logic [CW-1:0]       count;
    logic [IN_WIDTH-1:0] rem;
    logic [IN_WIDTH-1:0] quo;
    logic [IN_WIDTH-1:0] dvs;
    logic [IN_WIDTH:0]   rem_shift;
    logic [IN_WIDTH-1:0] rem_next;
    logic [IN_WIDTH-1:0] quo_next;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor only if it fits.
    always_comb begin
        rem_shift = {rem, quo[IN_WIDTH-1]};
        rem_next  = rem_shift[IN_WIDTH-1:0];
        quo_next  = {quo[IN_WIDTH-2:0], 1'b0};
        if (rem_shift >= {1'b0, dvs}) begin
            rem_next = IN_WIDTH'(rem_shift - {1'b0, dvs});
            quo_next = {quo[IN_WIDTH-2:0], 1'b1};
        end
    end

    assign done     = (count == CW'(1));
    assign quotient = quo_next;

    // The quotient register doubles as the dividend shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
        end else if (start) begin
            count <= CW'(IN_WIDTH);
            rem   <= '0;
            quo   <= dividend;
            dvs   <= divisor;
        end else if (count != '0) begin
            count <= count - CW'(1);
            rem   <= rem_next;
            quo   <= quo_next;
        end
    end

endmodule

// File: rtl/calc_engine.sv
// -----------------------------------------------------------------------------
// calc_engine
// Button-driven two-operand calculator: enter A, enter B, pick an operation.
//   clk, rst     : clock and asynchronous active-high reset
//   in_number    : unsigned operand sampled on an enter press
//   key          : enter buttons, bit0 = operand A, bit1 = operand B
//   arif         : operation buttons, bit0 +, bit1 -, bit2 *, bit3 /
//   result       : signed RES_WIDTH-bit result of the last operation
//   result_valid : one-cycle pulse whenever result/error update
//   error        : set when the last operation divided by zero
//   busy         : high while a division is running
//   led          : one-hot entry stage (001 A, 010 B, 100 ready/dividing)
// -----------------------------------------------------------------------------
module calc_engine
    import calc_pkg::*;
#(
    parameter  int IN_WIDTH  = 4,
    localparam int RES_WIDTH = 2 * IN_WIDTH + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  in_number,
    input  logic [1:0]           key,
    input  logic [3:0]           arif,
    output logic [RES_WIDTH-1:0] result,
    output logic                 result_valid,
    output logic                 error,
    output logic                 busy,
    output logic [2:0]           led
);

    localparam int PAD = RES_WIDTH - IN_WIDTH;

    state_t               state, state_next;
    logic [IN_WIDTH-1:0]  a_reg, a_next;
    logic [IN_WIDTH-1:0]  b_reg, b_next;
    logic [RES_WIDTH-1:0] result_reg, result_next;
    logic                 valid_reg, valid_next;
    logic                 error_reg, error_next;
    logic [1:0]           key_q;
    logic [3:0]           arif_q;
    logic                 primed;
    logic [1:0]           key_ev;
    logic [3:0]           arif_ev;
    logic [RES_WIDTH-1:0] a_ext, b_ext;
    logic                 div_start;
    logic                 div_done;
    logic [IN_WIDTH-1:0]  quotient;

    // No events on the first edge after reset: a button already held at
    // release is captured into the edge registers and must be released
    // before it can produce a press.
    assign key_ev  = primed ? (key  & ~key_q)  : 2'b00;
    assign arif_ev = primed ? (arif & ~arif_q) : 4'b0000;

    assign a_ext = {{PAD{1'b0}}, a_reg};
    assign b_ext = {{PAD{1'b0}}, b_reg};

    calc_divider #(.IN_WIDTH(IN_WIDTH)) u_divider (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (a_reg),
        .divisor  (b_reg),
        .done     (div_done),
        .quotient (quotient)
    );

    // Next-state logic. Enter keys take precedence over operation buttons,
    // and every button event is ignored while dividing.
    always_comb begin
        state_next  = state;
        a_next      = a_reg;
        b_next      = b_reg;
        result_next = result_reg;
        valid_next  = 1'b0;
        error_next  = error_reg;
        div_start   = 1'b0;
        case (state)
            WAIT_A, WAIT_B, READY: begin
                if (key_ev[0]) begin
                    a_next     = in_number;
                    error_next = 1'b0;
                    state_next = WAIT_B;
                end else if (key_ev[1] && state != WAIT_A) begin
                    b_next     = in_number;
                    state_next = READY;
                end else if (state == READY && arif_ev != 4'b0000) begin
                    valid_next = 1'b1;
                    error_next = 1'b0;
                    state_next = WAIT_A;
                    case (pick_operation(arif_ev))
                        PLUS:           result_next = a_ext + b_ext;
                        SUBTRACTION:    result_next = a_ext - b_ext;
                        MULTIPLICATION: result_next = a_ext * b_ext;
                        DIVISION: begin
                            if (b_reg == '0) begin
                                result_next = '0;
                                error_next  = 1'b1;
                            end else begin
                                valid_next  = 1'b0;
                                div_start   = 1'b1;
                                state_next  = DIVIDE;
                            end
                        end
                        default:        result_next = result_reg;
                    endcase
                end
            end
            DIVIDE: begin
                if (div_done) begin
                    result_next = {{PAD{1'b0}}, quotient};
                    valid_next  = 1'b1;
                    error_next  = 1'b0;
                    state_next  = WAIT_A;
                end
            end
            default: state_next = WAIT_A;
        endcase
    end

    // State, operand and result registers plus the button edge history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= WAIT_A;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            valid_reg  <= 1'b0;
            error_reg  <= 1'b0;
            key_q      <= '0;
            arif_q     <= '0;
            primed     <= 1'b0;
        end else begin
            state      <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            result_reg <= result_next;
            valid_reg  <= valid_next;
            error_reg  <= error_next;
            key_q      <= key;
            arif_q     <= arif;
            primed     <= 1'b1;
        end
    end

    // Stage indicator and busy flag decoded from the current state.
    always_comb begin
        led  = LED_WAIT_A;
        busy = 1'b0;
        case (state)
            WAIT_A: led = LED_WAIT_A;
            WAIT_B: led = LED_WAIT_B;
            READY:  led = LED_READY;
            DIVIDE: begin
                led  = LED_READY;
                busy = 1'b1;
            end
            default: led = LED_WAIT_A;
        endcase
    end

    assign result       = result_reg;
    assign result_valid = valid_reg;
    assign error        = error_reg;

endmodule

// File: tb/tb_calc_engine.sv
// -----------------------------------------------------------------------------
// tb_calc_engine
// Self-checking bench for calc_engine with IN_WIDTH = 4. Directed scenarios
// followed by randomized operations compared against an arithmetic model.
// -----------------------------------------------------------------------------
module tb_calc_engine;

    localparam int IW = 4;
    localparam int RW = 2 * IW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] in_number;
    logic [1:0]    key;
    logic [3:0]    arif;
    logic [RW-1:0] result;
    logic          result_valid;
    logic          error;
    logic          busy;
    logic [2:0]    led;

    int checks      = 0;
    int failures    = 0;
    int valid_count = 0;

    calc_engine #(.IN_WIDTH(IW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_number    (in_number),
        .key          (key),
        .arif         (arif),
        .result       (result),
        .result_valid (result_valid),
        .error        (error),
        .busy         (busy),
        .led          (led)
    );

    always #5 clk = ~clk;

    // Count result_valid pulses away from the active edge.
    always @(negedge clk) begin
        if (result_valid === 1'b1)
            valid_count++;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Arithmetic reference: plain integer maths truncated to the result width.
    function automatic logic [RW-1:0] model_result(input int op, input int a, input int b);
        int r;
        case (op)
            0:       r = a + b;
            1:       r = a - b;
            2:       r = a * b;
            default: r = (b == 0) ? 0 : a / b;
        endcase
        return r[RW-1:0];
    endfunction

    function automatic int first_op(input logic [3:0] mask);
        for (int i = 0; i < 4; i++)
            if (mask[i]) return i;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_operands(input int a, input int b);
        in_number = IW'(a); key = 2'b01; tick();
        key = 2'b00; tick();
        in_number = IW'(b); key = 2'b10; tick();
        key = 2'b00; tick();
    endtask

    task automatic run_op(input int a, input int b, input logic [3:0] mask,
                          output int lat, output logic [RW-1:0] res, output logic err);
        load_operands(a, b);
        arif = mask; tick();
        arif = 4'b0000;
        lat = 0;
        while (result_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        res = result;
        err = error;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_number = '0; key = '0; arif = '0;
        tick(); tick();
        checks++; if (led !== 3'b001) begin failures++; $display("[TB] FAIL reset_led got=%b exp=001", led); end
        checks++; if (result !== '0) begin failures++; $display("[TB] FAIL reset_result got=%0h exp=0", result); end
        checks++; if (result_valid !== 1'b0 || error !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_flags got valid=%b err=%b busy=%b exp=000", result_valid, error, busy);
        end
        rst = 1'b0; tick();
        checks++; if (led !== 3'b001) begin failures++; $display("[TB] FAIL post_reset_led got=%b exp=001", led); end
    endtask

    task automatic test_basic_sub();
        valid_count = 0;
        in_number = 4'd9; key = 2'b01; tick();
        checks++; if (led !== 3'b010) begin failures++; $display("[TB] FAIL sub_led_b got=%b exp=010", led); end
        key = 2'b00; tick();
        in_number = 4'd4; key = 2'b10; tick();
        checks++; if (led !== 3'b100) begin failures++; $display("[TB] FAIL sub_led_ready got=%b exp=100", led); end
        key = 2'b00; tick();
        arif = 4'b0010; tick();
        checks++; if (result_valid !== 1'b1) begin failures++; $display("[TB] FAIL sub_valid got=%b exp=1", result_valid); end
        checks++; if (result !== model_result(1, 9, 4)) begin failures++; $display("[TB] FAIL sub_result got=%0d exp=5", result); end
        checks++; if (led !== 3'b001) begin failures++; $display("[TB] FAIL sub_led_a got=%b exp=001", led); end
        arif = 4'b0000; tick(); tick();
        checks++; if (valid_count !== 1) begin failures++; $display("[TB] FAIL sub_pulses got=%0d exp=1", valid_count); end
    endtask

    task automatic test_negative();
        int lat; logic [RW-1:0] res; logic err;
        logic [RW-1:0] exp_neg;
        exp_neg = RW'(-9);
        run_op(3, 12, 4'b0010, lat, res, err);
        checks++; if (res !== exp_neg) begin failures++; $display("[TB] FAIL neg_result got=%b exp=%b", res, exp_neg); end
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL neg_error got=%b exp=0", err); end
    endtask

    task automatic test_mul_div();
        int lat; int busy_cycles; logic [RW-1:0] res; logic err;
        run_op(15, 15, 4'b0100, lat, res, err);
        checks++; if (res !== RW'(225)) begin failures++; $display("[TB] FAIL mul_result got=%0d exp=225", res); end
        checks++; if (lat !== 0) begin failures++; $display("[TB] FAIL mul_latency got=%0d exp=0", lat); end
        load_operands(15, 4);
        arif = 4'b1000; tick();
        checks++; if (led !== 3'b100) begin failures++; $display("[TB] FAIL div_led got=%b exp=100", led); end
        arif = 4'b0000;
        busy_cycles = 0; lat = 0;
        while (result_valid !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cycles++;
            tick();
            lat++;
        end
        checks++; if (lat !== IW) begin failures++; $display("[TB] FAIL div_latency got=%0d exp=%0d", lat, IW); end
        checks++; if (busy_cycles !== IW) begin failures++; $display("[TB] FAIL div_busy got=%0d exp=%0d", busy_cycles, IW); end
        checks++; if (result !== RW'(3)) begin failures++; $display("[TB] FAIL div_result got=%0d exp=3", result); end
        checks++; if (led !== 3'b001 || busy !== 1'b0) begin failures++; $display("[TB] FAIL div_exit got led=%b busy=%b exp=001/0", led, busy); end
        tick();
    endtask

    task automatic test_div_zero();
        logic saw_busy;
        load_operands(7, 0);
        arif = 4'b1000; tick();
        saw_busy = busy;
        checks++; if (result_valid !== 1'b1 || error !== 1'b1) begin failures++; $display("[TB] FAIL dz_flags got valid=%b err=%b exp=11", result_valid, error); end
        checks++; if (result !== '0) begin failures++; $display("[TB] FAIL dz_result got=%0d exp=0", result); end
        arif = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (busy === 1'b1) saw_busy = 1'b1;
        end
        checks++; if (saw_busy !== 1'b0) begin failures++; $display("[TB] FAIL dz_busy got=1 exp=0"); end
        checks++; if (error !== 1'b1) begin failures++; $display("[TB] FAIL dz_sticky got=%b exp=1", error); end
        in_number = 4'd1; key = 2'b01; tick();
        checks++; if (error !== 1'b0) begin failures++; $display("[TB] FAIL dz_clear got=%b exp=0", error); end
        key = 2'b00; tick();
    endtask

    task automatic test_priority();
        load_operands(6, 2);
        arif = 4'b1111; tick();
        checks++; if (result !== model_result(0, 6, 2)) begin failures++; $display("[TB] FAIL prio_arif got=%0d exp=8", result); end
        arif = 4'b0000; tick();
        in_number = 4'd5; key = 2'b01; tick();
        key = 2'b00; tick();
        in_number = 4'd9; key = 2'b11; tick();
        checks++; if (led !== 3'b010) begin failures++; $display("[TB] FAIL prio_key_led got=%b exp=010", led); end
        key = 2'b00; tick();
        in_number = 4'd3; key = 2'b10; tick();
        key = 2'b00; tick();
        arif = 4'b0001; tick();
        checks++; if (result !== model_result(0, 9, 3)) begin failures++; $display("[TB] FAIL prio_key_a got=%0d exp=12", result); end
        arif = 4'b0000; tick();
    endtask

    task automatic test_reset_mid_divide();
        load_operands(15, 1);
        valid_count = 0;
        arif = 4'b1000; tick();
        tick(); tick();
        rst = 1'b1; #1;
        checks++; if (led !== 3'b001 || busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_div_state got led=%b busy=%b exp=001/0", led, busy); end
        checks++; if (result !== '0) begin failures++; $display("[TB] FAIL rst_div_result got=%0d exp=0", result); end
        key = 2'b01; in_number = 4'd7;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++; if (valid_count !== 0) begin failures++; $display("[TB] FAIL rst_div_pulses got=%0d exp=0", valid_count); end
        checks++; if (led !== 3'b001) begin failures++; $display("[TB] FAIL rst_held_led got=%b exp=001", led); end
        key = 2'b00; arif = 4'b0000; tick();
        key = 2'b01; tick();
        checks++; if (led !== 3'b010) begin failures++; $display("[TB] FAIL rst_repress_led got=%b exp=010", led); end
        key = 2'b00; tick();
    endtask

    task automatic test_random();
        int a, b, op, lat, exp_lat; logic [3:0] mask; logic [RW-1:0] res; logic err;
        for (int n = 0; n < 24; n++) begin
            a = int'($urandom_range(0, 15));
            b = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 15));
            mask = 4'($urandom_range(1, 15));
            op = first_op(mask);
            exp_lat = (op == 3 && b != 0) ? IW : 0;
            run_op(a, b, mask, lat, res, err);
            checks++; if (res !== model_result(op, a, b)) begin failures++; $display("[TB] FAIL rand_result op=%0d a=%0d b=%0d got=%0h exp=%0h", op, a, b, res, model_result(op, a, b)); end
            checks++; if (err !== (op == 3 && b == 0)) begin failures++; $display("[TB] FAIL rand_error op=%0d b=%0d got=%b", op, b, err); end
            checks++; if (lat !== exp_lat) begin failures++; $display("[TB] FAIL rand_latency op=%0d got=%0d exp=%0d", op, lat, exp_lat); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_sub();
        test_negative();
        test_mul_div();
        test_div_zero();
        test_priority();
        test_reset_mid_divide();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
